// File: rtl/biquad_seq_ctrl.sv
// rtl/biquad_seq_ctrl.sv - sequencer FSM for the shared-MAC DF-II biquad datapath
//
// Per sample, sequences the shared MAC through five steps:
//   fk = Uk + a1*fk1 + a2*fk2    (a1/a2 are stored negated)
//   yk = b0*fk + b1*fk1 + b2*fk2
// then shifts the delay line.
//
// Ports:
//   clk          in   rising-edge system clock
//   reset_n      in   asynchronous active-low reset
//   start        in   sample strobe, accepted only in IDLE
//   clr          in   zero-state request, accepted only in IDLE, wins over start
//   controlS     out  coef select  (0 cero,1 a1,2 a2,3 b0,4 b1,5 b2)
//   controlC     out  state select (0 cero,1 fk1,2 fk2,3 fk)
//   controlZ     out  addend select(0 cero,1 Uk,2 yk,3 acum1,4 acum2,5 acum3)
//   en_uk, en_acum1, en_acum3, en_fk, en_yk, en_shift, en_clr  out  datapath enables
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse, new yk valid
//   overrun_cnt  out  (BIQUAD_OVERRUN_CNT_EN only) saturating count of starts seen while busy
//
// Parameter MAC_LAT (1..15): cycles each MAC step holds its selects.
// Optional feature macro: BIQUAD_OVERRUN_CNT_EN.
// All outputs are registered: they are decoded from the next state and
// captured in the same flop stage as the state register.

module biquad_seq_ctrl #(
    parameter int MAC_LAT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       clr,
    output logic [2:0] controlS,
    output logic [1:0] controlC,
    output logic [2:0] controlZ,
    output logic       en_uk,
    output logic       en_acum1,
    output logic       en_acum3,
    output logic       en_fk,
    output logic       en_yk,
    output logic       en_shift,
    output logic       en_clr,
    output logic       busy,
`ifdef BIQUAD_OVERRUN_CNT_EN
    output logic       done,
    output logic [7:0] overrun_cnt
`else
    output logic       done
`endif
);

    typedef enum logic [3:0] {
        IDLE, LOAD, S1, S2, S3, S4, S5, SHIFT, DONE, CLEAR
    } state_t;

    localparam logic [3:0] RELOAD = 4'(MAC_LAT - 1);

    state_t     state, state_nx;
    logic [3:0] wcnt, wcnt_nx;

    logic [2:0] s_nx, z_nx;
    logic [1:0] c_nx;
    logic       uk_nx, a1_nx, a3_nx, fk_nx, yk_nx, sh_nx, clr_nx, busy_nx, done_nx;
    logic       last_nx;

    // Next state and wait counter. The counter reloads on every Sn entry
    // and counts down to zero; zero marks the final cycle of the step.
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            IDLE: begin
                if (clr)        state_nx = CLEAR;
                else if (start) state_nx = LOAD;
            end
            LOAD: begin
                state_nx = S1;
                wcnt_nx  = RELOAD;
            end
            S1, S2, S3, S4, S5: begin
                if (wcnt == 4'd0) begin
                    wcnt_nx = RELOAD;
                    case (state)
                        S1:      state_nx = S2;
                        S2:      state_nx = S3;
                        S3:      state_nx = S4;
                        S4:      state_nx = S5;
                        default: state_nx = SHIFT;
                    endcase
                end else begin
                    wcnt_nx = wcnt - 4'd1;
                end
            end
            SHIFT:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            CLEAR:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flops present them
    // in the same cycle the state is entered.
    always_comb begin
        s_nx    = 3'd0;
        c_nx    = 2'd0;
        z_nx    = 3'd0;
        uk_nx   = 1'b0;
        a1_nx   = 1'b0;
        a3_nx   = 1'b0;
        fk_nx   = 1'b0;
        yk_nx   = 1'b0;
        sh_nx   = 1'b0;
        clr_nx  = 1'b0;
        done_nx = 1'b0;
        busy_nx = (state_nx != IDLE);
        last_nx = (wcnt_nx == 4'd0);
        case (state_nx)
            LOAD:  uk_nx = 1'b1;
            S1: begin s_nx = 3'd1; c_nx = 2'd1; z_nx = 3'd1; a1_nx = last_nx; end
            S2: begin s_nx = 3'd2; c_nx = 2'd2; z_nx = 3'd3; fk_nx = last_nx; end
            S3: begin s_nx = 3'd3; c_nx = 2'd3; z_nx = 3'd0; a3_nx = last_nx; end
            S4: begin s_nx = 3'd4; c_nx = 2'd1; z_nx = 3'd5; a1_nx = last_nx; end
            S5: begin s_nx = 3'd5; c_nx = 2'd2; z_nx = 3'd3; yk_nx = last_nx; end
            SHIFT: sh_nx   = 1'b1;
            DONE:  done_nx = 1'b1;
            CLEAR: clr_nx  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            wcnt     <= 4'd0;
            controlS <= 3'd0;
            controlC <= 2'd0;
            controlZ <= 3'd0;
            en_uk    <= 1'b0;
            en_acum1 <= 1'b0;
            en_acum3 <= 1'b0;
            en_fk    <= 1'b0;
            en_yk    <= 1'b0;
            en_shift <= 1'b0;
            en_clr   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            wcnt     <= wcnt_nx;
            controlS <= s_nx;
            controlC <= c_nx;
            controlZ <= z_nx;
            en_uk    <= uk_nx;
            en_acum1 <= a1_nx;
            en_acum3 <= a3_nx;
            en_fk    <= fk_nx;
            en_yk    <= yk_nx;
            en_shift <= sh_nx;
            en_clr   <= clr_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

`ifdef BIQUAD_OVERRUN_CNT_EN
    // Counts ignored strobes only; never feeds back into sequencing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_cnt <= 8'd0;
        end else if (state == CLEAR) begin
            overrun_cnt <= 8'd0;
        end else if (start && busy && overrun_cnt != 8'hFF) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_biquad_seq_ctrl.sv
// tb/tb_biquad_seq_ctrl.sv - self-checking bench for biquad_seq_ctrl (MAC_LAT 1 and 3)

module tb_biquad_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n, start, clr;
    always #5 clk = ~clk;

    logic [2:0] cs [2];
    logic [1:0] cc [2];
    logic [2:0] cz [2];
    logic       e_uk [2], e_a1 [2], e_a3 [2], e_fk [2], e_yk [2];
    logic       e_sh [2], e_cl [2], bsy [2], dn [2];
    logic [7:0] ovr [2];
    logic [16:0] act [2];

    int cmp_cnt = 0;
    int bad_cnt = 0;

    biquad_seq_ctrl #(.MAC_LAT(1)) dut1 (
        .clk(clk), .reset_n(rst_n), .start(start), .clr(clr),
        .controlS(cs[0]), .controlC(cc[0]), .controlZ(cz[0]),
        .en_uk(e_uk[0]), .en_acum1(e_a1[0]), .en_acum3(e_a3[0]), .en_fk(e_fk[0]),
        .en_yk(e_yk[0]), .en_shift(e_sh[0]), .en_clr(e_cl[0]), .busy(bsy[0]),
`ifdef BIQUAD_OVERRUN_CNT_EN
        .done(dn[0]), .overrun_cnt(ovr[0])
`else
        .done(dn[0])
`endif
    );

    biquad_seq_ctrl #(.MAC_LAT(3)) dut3 (
        .clk(clk), .reset_n(rst_n), .start(start), .clr(clr),
        .controlS(cs[1]), .controlC(cc[1]), .controlZ(cz[1]),
        .en_uk(e_uk[1]), .en_acum1(e_a1[1]), .en_acum3(e_a3[1]), .en_fk(e_fk[1]),
        .en_yk(e_yk[1]), .en_shift(e_sh[1]), .en_clr(e_cl[1]), .busy(bsy[1]),
`ifdef BIQUAD_OVERRUN_CNT_EN
        .done(dn[1]), .overrun_cnt(ovr[1])
`else
        .done(dn[1])
`endif
    );

`ifndef BIQUAD_OVERRUN_CNT_EN
    assign ovr[0] = 8'd0;
    assign ovr[1] = 8'd0;
`endif

    // Packed view: {S[2:0],C[1:0],Z[2:0],uk,acum1,acum3,fk,yk,shift,clr,busy,done}
    always_comb begin
        for (int i = 0; i < 2; i++)
            act[i] = {cs[i], cc[i], cz[i], e_uk[i], e_a1[i], e_a3[i], e_fk[i],
                      e_yk[i], e_sh[i], e_cl[i], bsy[i], dn[i]};
    end

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        cmp_cnt++;
        if (a !== e) begin
            bad_cnt++;
            if (bad_cnt <= 40)
                $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, a, e);
        end
    endtask

    // Expected outputs from the position within a sequence: pos 1 is the
    // sample load, then five steps of l cycles each (enable on the last),
    // then shift, then done.
    function automatic logic [16:0] exp_vec(int mode, int pos, int l);
        logic [16:0] v;
        int k, ph;
        v = '0;
        if (mode == 2) begin
            v[2] = 1'b1;
            v[1] = 1'b1;
        end else if (mode == 1) begin
            v[1] = 1'b1;
            if (pos == 1) begin
                v[8] = 1'b1;
            end else if (pos <= 5 * l + 1) begin
                k  = (pos - 2) / l;
                ph = (pos - 2) % l;
                case (k)
                    0: begin v[16:9] = {3'd1, 2'd1, 3'd1}; v[7] = (ph == l - 1); end
                    1: begin v[16:9] = {3'd2, 2'd2, 3'd3}; v[5] = (ph == l - 1); end
                    2: begin v[16:9] = {3'd3, 2'd3, 3'd0}; v[6] = (ph == l - 1); end
                    3: begin v[16:9] = {3'd4, 2'd1, 3'd5}; v[7] = (ph == l - 1); end
                    default: begin v[16:9] = {3'd5, 2'd2, 3'd3}; v[4] = (ph == l - 1); end
                endcase
            end else if (pos == 5 * l + 2) begin
                v[3] = 1'b1;
            end else begin
                v[0] = 1'b1;
            end
        end
        return v;
    endfunction

    // Model: mode 0 idle, 1 filtering, 2 clearing; pos counts cycles since acceptance.
    int m_mode [2];
    int m_pos  [2];
    int m_ovr  [2];
    int lat    [2];
    initial begin
        lat[0] = 1;
        lat[1] = 3;
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_mode[i] = 0; m_pos[i] = 0; m_ovr[i] = 0;
            end else if (m_mode[i] == 0) begin
                if (clr)        begin m_mode[i] = 2; m_pos[i] = 1; end
                else if (start) begin m_mode[i] = 1; m_pos[i] = 1; end
            end else begin
                if (m_mode[i] == 2)                m_ovr[i] = 0;
                else if (start && m_ovr[i] < 255)  m_ovr[i] = m_ovr[i] + 1;
                if (m_mode[i] == 2 || m_pos[i] == 5 * lat[i] + 3) begin
                    m_mode[i] = 0; m_pos[i] = 0;
                end else begin
                    m_pos[i] = m_pos[i] + 1;
                end
            end
        end
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        check("outs_lat1", {15'd0, act[0]}, {15'd0, exp_vec(m_mode[0], m_pos[0], lat[0])});
        check("outs_lat3", {15'd0, act[1]}, {15'd0, exp_vec(m_mode[1], m_pos[1], lat[1])});
`ifdef BIQUAD_OVERRUN_CNT_EN
        check("ovr_lat1", {24'd0, ovr[0]}, m_ovr[0]);
        check("ovr_lat3", {24'd0, ovr[1]}, m_ovr[1]);
`endif
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int d1, d3, n_clr, n_done, n_uk, n_done3;
    bit found;

    initial begin
        rst_n = 1'b0; start = 1'b0; clr = 1'b0;
        repeat (3) tick();
        check("reset_lat1", {15'd0, act[0]}, 32'd0);
        check("reset_lat3", {15'd0, act[1]}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Single sample: latency and literal select tuples.
        start = 1'b1; d1 = 0; d3 = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 2) check("l1_c2_s1",  {15'd0, act[0]}, {15'd0, 3'd1, 2'd1, 3'd1, 9'b010000010});
            if (c == 6) check("l1_c6_s5",  {15'd0, act[0]}, {15'd0, 3'd5, 2'd2, 3'd3, 9'b000010010});
            if (c == 7) check("l1_c7_sh",  {15'd0, act[0]}, {15'd0, 8'd0, 9'b000001010});
            if (c == 3) check("l3_c3_hold", {15'd0, act[1]}, {15'd0, 3'd1, 2'd1, 3'd1, 9'b000000010});
            if (c == 4) check("l3_c4_en",  {15'd0, act[1]}, {15'd0, 3'd1, 2'd1, 3'd1, 9'b010000010});
            if (dn[0] && d1 == 0) d1 = c;
            if (dn[1] && d3 == 0) d3 = c;
            #1;
            start = 1'b0;
        end
        check("done_cyc_lat1", d1, 8);
        check("done_cyc_lat3", d3, 18);

        // start and clr together: clear wins, no sequence.
        start = 1'b1; clr = 1'b1;
        n_clr = 0; n_done = 0; n_uk = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            n_clr  += int'(e_cl[0]);
            n_done += int'(dn[0]);
            n_uk   += int'(e_uk[0]);
            #1;
            start = 1'b0; clr = 1'b0;
        end
        check("clr_pulses", n_clr, 1);
        check("clr_no_done", n_done, 0);
        check("clr_no_load", n_uk, 0);

        // Stray start mid-sequence is ignored.
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        n_done = 0; n_done3 = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            n_done  += int'(dn[0]);
            n_done3 += int'(dn[1]);
            #1;
        end
        check("stray_one_done_l1", n_done, 1);
        check("stray_one_done_l3", n_done3, 1);
`ifdef BIQUAD_OVERRUN_CNT_EN
        check("stray_ovr_l1", ovr[0], 1);
        check("stray_ovr_l3", ovr[1], 1);
`endif

        // Back-to-back: start in the IDLE cycle right after done.
        start = 1'b1; tick(); start = 1'b0;
        found = 1'b0;
        for (int c = 1; c <= 30 && !found; c++) begin
            @(negedge clk);
            if (dn[0]) found = 1'b1;
            #1;
        end
        check("b2b_first_done_seen", {31'd0, found}, 32'd1);
        tick();
        start = 1'b1; d1 = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (dn[0] && d1 == 0) d1 = c;
            #1;
            start = 1'b0;
        end
        check("b2b_done_cyc", d1, 8);

        // Reset asserted while the MAC_LAT=1 instance sits in S3.
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 4) check("pre_rst_s3", {29'd0, cs[0]}, 32'd3);
            #1;
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("async_rst_l1", {15'd0, act[0]}, 32'd0);
        check("async_rst_l3", {15'd0, act[1]}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_idle", {15'd0, act[0]}, 32'd0);

        // Held start: many strobes while busy saturate the overrun count.
        start = 1'b1;
        repeat (300) tick();
        start = 1'b0;
        repeat (25) tick();
`ifdef BIQUAD_OVERRUN_CNT_EN
        check("ovr_sat_l1", ovr[0], 255);
        check("ovr_sat_l3", ovr[1], 255);
`endif
        clr = 1'b1; tick(); clr = 1'b0;
        tick(); tick();
`ifdef BIQUAD_OVERRUN_CNT_EN
        check("ovr_cleared", ovr[0], 0);
`endif
        check("final_idle", {31'd0, bsy[0]}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

endmodule
